// File: rtl/tron_board_pkg.sv
// tron_board_pkg: shared board geometry, cell colours and scheduler states.
package tron_board_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam logic [2:0] EMPTY = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] P3 = 3'b100;
  localparam logic [2:0] P4 = 3'b110;
  localparam logic [2:0] CRASH = 3'b111;
  typedef enum logic {CLEAR, ARB} state_t;
endpackage

// File: rtl/board_clear_sweeper.sv
// board_clear_sweeper: address counter for the clear sweep, terminal detect and done pulse.
module board_clear_sweeper #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  output logic [ADDR_W-1:0] cnt,
  output logic              last,
  output logic              done
);
  assign last = &cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      done <= 1'b0;
    end else begin
      cnt <= start ? '0 : run ? cnt + 1'b1 : cnt;
      done <= run && last;
    end
  end
endmodule

// File: rtl/board_ram_scheduler.sv
// board_ram_scheduler: single owner of the board RAM port; clear sweep, then
// game-priority arbitration with a VGA starvation override.
module board_ram_scheduler #(
  parameter int ADDR_W = tron_board_pkg::ADDR_W,
  parameter int DATA_W = tron_board_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = tron_board_pkg::EMPTY,
  parameter int VGA_MAX_WAIT = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  import tron_board_pkg::*;
  localparam int WW = $clog2(VGA_MAX_WAIT + 1);
  state_t state, state_nx;
  logic [WW-1:0] vga_wait;
  logic [ADDR_W-1:0] sweep_cnt, last_addr, addr_mux;
  logic sweep_last, arb, starve, g_rv, v_rv;
  assign arb = state == ARB;
  assign starve = v_req && vga_wait >= WW'(VGA_MAX_WAIT);
  board_clear_sweeper #(.ADDR_W(ADDR_W)) u_sweeper (
    .clk(CLOCK_50),
    .rst_n(resetn),
    .start(arb && clear_start),
    .run(!arb),
    .cnt(sweep_cnt),
    .last(sweep_last),
    .done(clear_done)
  );
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= CLEAR_ON_RESET ? CLEAR : ARB;
    else state <= state_nx;
  end
  always_comb state_nx = arb ? (clear_start ? CLEAR : ARB) : (sweep_last ? ARB : CLEAR);
  // Outputs are gated by resetn so they drop to 0 immediately, even though state resets to CLEAR.
  always_comb begin
    g_gnt = resetn && arb && !clear_start && g_req && !starve;
    v_gnt = resetn && arb && !clear_start && v_req && !g_gnt;
    addr_mux = !arb ? sweep_cnt : g_gnt ? g_addr : v_gnt ? v_addr : last_addr;
    ram_address = resetn ? addr_mux : '0;
    ram_wren = resetn && (!arb || (g_gnt && g_we));
    ram_data = !resetn ? '0 : !arb ? CLEAR_VALUE : g_gnt ? g_wdata : '0;
    clear_busy = resetn && !arb;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_wait <= '0;
      last_addr <= '0;
      g_rv <= 1'b0;
      v_rv <= 1'b0;
    end else begin
      vga_wait <= !arb ? vga_wait : (!v_req || v_gnt) ? '0 : starve ? vga_wait : vga_wait + 1'b1;
      last_addr <= addr_mux;
      g_rv <= g_gnt && !g_we;
      v_rv <= v_gnt;
    end
  end
  assign g_rvalid = g_rv;
  assign v_rvalid = v_rv;
  assign g_rdata = g_rv ? ram_q : '0;
  assign v_rdata = v_rv ? ram_q : '0;
endmodule

// File: tb/tb_board_ram_scheduler.sv
// tb_board_ram_scheduler: directed checks of clear sweep, arbitration and read path
// against a behavioural 1-cycle RAM, with a 16-cell board.
module tb_board_ram_scheduler;
  localparam int AW = 4;
  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b0;
  logic clear_start = 1'b0;
  logic clear_busy, clear_done;
  logic g_req = 1'b0, g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [2:0] g_wdata = '0;
  logic g_gnt, g_rvalid;
  logic [2:0] g_rdata;
  logic v_req = 1'b0;
  logic [AW-1:0] v_addr = '0;
  logic v_gnt, v_rvalid;
  logic [2:0] v_rdata;
  logic [AW-1:0] ram_address;
  logic [2:0] ram_data, ram_q;
  logic ram_wren;
  logic [2:0] mem [16];
  int tests = 0;
  int fails = 0;
  int dones;

  board_ram_scheduler #(.ADDR_W(AW), .DATA_W(3), .CLEAR_VALUE(3'b000), .VGA_MAX_WAIT(8), .CLEAR_ON_RESET(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
    .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    repeat (3) @(negedge CLOCK_50);
    #1;
    tests++;
    if ({clear_busy, clear_done, ram_wren, g_gnt, v_gnt, g_rvalid, v_rvalid} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000000", {clear_busy, clear_done, ram_wren, g_gnt, v_gnt, g_rvalid, v_rvalid});
    end
    tests++;
    if ({ram_address, ram_data, g_rdata, v_rdata} !== 13'b0) begin
      fails++;
      $display("FAIL reset_buses got %h want 0", {ram_address, ram_data, g_rdata, v_rdata});
    end
  endtask

  task automatic test_power_up_clear;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (ram_wren !== 1'b1 || ram_address !== AW'(i) || ram_data !== 3'b000 || clear_busy !== 1'b1 || clear_done !== 1'b0) begin
        fails++;
        $display("FAIL pwr_sweep[%0d] got wren=%b addr=%0d data=%b busy=%b done=%b want 1 %0d 000 1 0",
                 i, ram_wren, ram_address, ram_data, clear_busy, clear_done, i);
      end
      @(negedge CLOCK_50);
      #1;
    end
    tests++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0 || ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL pwr_done got done=%b busy=%b wren=%b want 1 0 0", clear_done, clear_busy, ram_wren);
    end
    @(negedge CLOCK_50);
    #1;
    tests++;
    if (clear_done !== 1'b0) begin
      fails++;
      $display("FAIL pwr_done_pulse got %b want 0", clear_done);
    end
  endtask

  task automatic test_write_read;
    @(negedge CLOCK_50);
    g_req = 1'b1; g_we = 1'b1; g_addr = 4'hA; g_wdata = 3'b001;
    #1;
    tests++;
    if (g_gnt !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 4'hA || ram_data !== 3'b001) begin
      fails++;
      $display("FAIL wr_grant got gnt=%b wren=%b addr=%h data=%b want 1 1 a 001", g_gnt, ram_wren, ram_address, ram_data);
    end
    @(negedge CLOCK_50);
    g_we = 1'b0;
    #1;
    tests++;
    if (g_gnt !== 1'b1 || ram_wren !== 1'b0 || g_rvalid !== 1'b0 || ram_address !== 4'hA) begin
      fails++;
      $display("FAIL rd_grant got gnt=%b wren=%b rvalid=%b addr=%h want 1 0 0 a", g_gnt, ram_wren, g_rvalid, ram_address);
    end
    @(negedge CLOCK_50);
    g_req = 1'b0;
    #1;
    tests++;
    if (g_rvalid !== 1'b1 || g_rdata !== 3'b001 || g_gnt !== 1'b0) begin
      fails++;
      $display("FAIL rd_data got rvalid=%b rdata=%b gnt=%b want 1 001 0", g_rvalid, g_rdata, g_gnt);
    end
    @(negedge CLOCK_50);
    v_req = 1'b1; v_addr = 4'hA;
    #1;
    tests++;
    if (g_rvalid !== 1'b0 || g_rdata !== 3'b000 || v_gnt !== 1'b1 || ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL v_grant got g_rvalid=%b g_rdata=%b v_gnt=%b wren=%b want 0 000 1 0", g_rvalid, g_rdata, v_gnt, ram_wren);
    end
    @(negedge CLOCK_50);
    v_req = 1'b0; v_addr = 4'h3;
    #1;
    tests++;
    if (v_rvalid !== 1'b1 || v_rdata !== 3'b001 || ram_address !== 4'hA || ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL v_read_idle got rvalid=%b rdata=%b addr=%h wren=%b want 1 001 a 0", v_rvalid, v_rdata, ram_address, ram_wren);
    end
  endtask

  task automatic test_starvation;
    @(negedge CLOCK_50);
    g_req = 1'b1; g_we = 1'b0; g_addr = 4'h2; v_req = 1'b1; v_addr = 4'hA;
    for (int c = 1; c <= 20; c++) begin
      #1;
      tests++;
      if (v_gnt !== (c % 9 == 0) || g_gnt !== (c % 9 != 0) || v_rvalid !== (c % 9 == 1 && c > 1)) begin
        fails++;
        $display("FAIL starve[%0d] got g_gnt=%b v_gnt=%b v_rvalid=%b want %b %b %b",
                 c, g_gnt, v_gnt, v_rvalid, c % 9 != 0, c % 9 == 0, c % 9 == 1 && c > 1);
      end
      if (c % 9 == 1 && c > 1) begin
        tests++;
        if (v_rdata !== 3'b001) begin
          fails++;
          $display("FAIL starve_rdata[%0d] got %b want 001", c, v_rdata);
        end
      end
      @(negedge CLOCK_50);
    end
    g_req = 1'b0; v_req = 1'b0;
  endtask

  task automatic test_clear_with_req;
    @(negedge CLOCK_50);
    g_req = 1'b1; g_we = 1'b1; g_addr = 4'h5; g_wdata = 3'b010;
    @(negedge CLOCK_50);
    g_we = 1'b0; clear_start = 1'b1;
    #1;
    tests++;
    if (g_gnt !== 1'b0 || clear_busy !== 1'b0) begin
      fails++;
      $display("FAIL clr_start_cycle got gnt=%b busy=%b want 0 0", g_gnt, clear_busy);
    end
    @(negedge CLOCK_50);
    clear_start = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (g_gnt !== 1'b0 || clear_busy !== 1'b1 || ram_wren !== 1'b1 || ram_address !== AW'(i)) begin
        fails++;
        $display("FAIL clr_sweep[%0d] got gnt=%b busy=%b wren=%b addr=%0d want 0 1 1 %0d", i, g_gnt, clear_busy, ram_wren, ram_address, i);
      end
      @(negedge CLOCK_50);
      #1;
    end
    tests++;
    if (clear_done !== 1'b1 || g_gnt !== 1'b1 || ram_address !== 4'h5) begin
      fails++;
      $display("FAIL clr_regrant got done=%b gnt=%b addr=%h want 1 1 5", clear_done, g_gnt, ram_address);
    end
    @(negedge CLOCK_50);
    g_req = 1'b0;
    #1;
    tests++;
    if (g_rvalid !== 1'b1 || g_rdata !== 3'b000) begin
      fails++;
      $display("FAIL clr_cleared got rvalid=%b rdata=%b want 1 000", g_rvalid, g_rdata);
    end
  endtask

  task automatic test_reset_mid_sweep;
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    @(negedge CLOCK_50);
    clear_start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    #1;
    tests++;
    if (ram_address !== 4'd5 || clear_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_pos got addr=%0d busy=%b want 5 1", ram_address, clear_busy);
    end
    resetn = 1'b0;
    #1;
    tests++;
    if ({clear_busy, clear_done, ram_wren, g_gnt, v_gnt, g_rvalid, v_rvalid} !== 7'b0 || {ram_address, ram_data} !== 7'b0) begin
      fails++;
      $display("FAIL mid_async got flags=%b addr=%0d data=%b want 0", {clear_busy, clear_done, ram_wren, g_gnt, v_gnt, g_rvalid, v_rvalid}, ram_address, ram_data);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (ram_address !== AW'(i) || ram_wren !== 1'b1 || clear_busy !== 1'b1) begin
        fails++;
        $display("FAIL mid_restart[%0d] got addr=%0d wren=%b busy=%b want %0d 1 1", i, ram_address, ram_wren, clear_busy, i);
      end
      @(negedge CLOCK_50);
      #1;
    end
    tests++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_done got done=%b busy=%b want 1 0", clear_done, clear_busy);
    end
  endtask

  task automatic test_restart_ignored;
    dones = 0;
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50);
      clear_start = (i == 7);
      #1;
      dones += int'(clear_done);
      tests++;
      if (ram_address !== AW'(i) || clear_busy !== 1'b1) begin
        fails++;
        $display("FAIL ign_sweep[%0d] got addr=%0d busy=%b want %0d 1", i, ram_address, clear_busy, i);
      end
    end
    clear_start = 1'b0;
    repeat (4) begin
      @(negedge CLOCK_50);
      #1;
      dones += int'(clear_done);
    end
    tests++;
    if (dones != 1 || clear_busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_done_count got dones=%0d busy=%b want 1 0", dones, clear_busy);
    end
  endtask

  initial begin
    test_reset;
    test_power_up_clear;
    test_write_read;
    test_starvation;
    test_clear_with_req;
    test_reset_mid_sweep;
    test_restart_ignored;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
